// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch, decode and execute stages.
//   - Program address and instruction word widths.
//   - Instruction field positions. The jump target lives in bits [7:0].
//   - Opcode and condition codes, used by decode/execute only.
//   - Fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 35;

  // Instruction field layout
  localparam int OPC_MSB  = 34;
  localparam int OPC_LSB  = 30;
  localparam int COND_MSB = 29;
  localparam int COND_LSB = 27;
  localparam int TGT_MSB  = 7;
  localparam int TGT_LSB  = 0;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_MOV = 5'h01;
  localparam logic [4:0] OP_ACC = 5'h02;
  localparam logic [4:0] OP_JMP = 5'h03;

  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_ZERO   = 3'd1;
  localparam logic [2:0] CC_NZERO  = 3'd2;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// program_counter: fetch PC register.
//   clk, rst_n : clock, asynchronous active-low reset
//   jump       : load target this edge (has priority over step)
//   target     : jump destination
//   step       : advance by PC_STEP this edge (wraps mod 2^ADDR_W)
//   pc         : current fetch PC
module program_counter #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              step,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= ADDR_W'(RESET_PC);
    else if (jump)
      pc <= target;
    else if (step)
      pc <= pc + ADDR_W'(PC_STEP);
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: CPU fetch stage.
//   Drives the ROM address from the fetch PC and captures the combinational
//   ROM word into the instruction register (ir/ir_pc). Downstream takes ir
//   with an ir_valid/ir_ready handshake. Execute can redirect fetch. A
//   halt_req level drains the IR and stops fetching until a resume pulse.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   rom_addr/rom_data : program ROM interface (data is combinational)
//   ir, ir_pc         : instruction register and the address it came from
//   ir_valid/ir_ready : handshake to decode/execute
//   redirect/_target  : jump request from execute
//   halt_req, resume  : halt level, resume pulse
//   halted            : fetch stopped with the IR drained
//   fetch_count       : number of completed handshakes (wrapping)
module instr_fetch #(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int INSTR_W  = cpu_pkg::INSTR_W,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  import cpu_pkg::*;

  fetch_state_t state;

  logic accept;
  logic jump;
  logic load;

  assign accept = ir_valid & ir_ready;
  // A halted fetch unit ignores redirects entirely.
  assign jump   = redirect & (state != S_HALTED);
  // Redirect wins over load: the cycle after a jump is always a bubble.
  assign load   = (state == S_RUN) & (!ir_valid | accept) & !redirect;

  program_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .jump  (jump),
    .target(redirect_target),
    .step  (load),
    .pc    (rom_addr)
  );

  // IR stage: capture the ROM word; a jump flushes even an accepted IR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (jump) begin
      ir_valid <= 1'b0;
    end else if (load) begin
      ir       <= rom_data;
      ir_pc    <= rom_addr;
      ir_valid <= 1'b1;
    end else if (accept) begin
      ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (accept)
      fetch_count <= fetch_count + 1'b1;
  end

  // Halt FSM with registered halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          // A same-cycle redirect postpones the halt by one cycle.
          if (halt_req && !redirect)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!halt_req) begin
            state <= S_RUN;
          end else if (!ir_valid || accept || redirect) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (resume) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rom_addr;
  logic [34:0]       rom_data;
  logic [34:0]       ir;
  logic [7:0]        ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [7:0]        redirect_target;
  logic              halt_req;
  logic              resume;
  logic              halted;
  logic [15:0]       fetch_count;

  logic [34:0] rom [256];
  logic [7:0]  exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk(input logic [4:0] op, input logic [7:0] t);
    logic [34:0] w;
    w = '0;
    w[34:30] = op;
    w[7:0]   = t;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(8'(i));
  endtask

  // Scoreboard: every handshake must match the next expected address/word.
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {56'd0, ir_pc}, 64'hFFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {56'd0, ir_pc}, {56'd0, e});
        chk("sb_word", {29'd0, ir}, {29'd0, rom[e]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = {3'b101, 8'(i), 8'(~i), 8'(i * 3), 8'h11};
    rom[0] = mk(OP_MOV, 8'h2A);
    rom[1] = '0;
    rom[2] = '0;
    rom[3] = '0;
    rom[4] = mk(OP_ACC, 8'h05);
    rom[8] = mk(OP_JMP, 8'd4);

    rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    halt_req = 1'b0; resume = 1'b0;
    #1;
    chk("rst_addr", {56'd0, rom_addr}, 64'd0);
    chk("rst_valid", {63'd0, ir_valid}, 64'd0);
    chk("rst_ir", {29'd0, ir}, 64'd0);
    chk("rst_irpc", {56'd0, ir_pc}, 64'd0);
    chk("rst_cnt", {48'd0, fetch_count}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Sequential fetch, including zero words
    push_range(0, 7);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_addr", {56'd0, rom_addr}, 64'(k));
      chk("seq_irpc", {56'd0, ir_pc}, 64'(k - 1));
      chk("seq_valid", {63'd0, ir_valid}, 64'd1);
    end

    // Stall with ir_pc=2
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_irpc", {56'd0, ir_pc}, 64'd2);
      chk("stall_ir", {29'd0, ir}, {29'd0, rom[2]});
      chk("stall_addr", {56'd0, rom_addr}, 64'd3);
      chk("stall_cnt", {48'd0, fetch_count}, 64'd2);
    end
    ir_ready = 1'b1;
    tick();
    chk("rel_irpc", {56'd0, ir_pc}, 64'd3);
    chk("rel_cnt", {48'd0, fetch_count}, 64'd3);
    for (int k = 0; k < 5; k++) tick();
    chk("pre_jmp_irpc", {56'd0, ir_pc}, 64'd8);

    // Redirect loop 8 -> 4, three times
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(8'd8);
      push_range(4, 7);
      redirect = 1'b1; redirect_target = ir[7:0];
      tick();
      redirect = 1'b0;
      chk("jmp_bubble", {63'd0, ir_valid}, 64'd0);
      chk("jmp_addr", {56'd0, rom_addr}, 64'd4);
      chk("jmp_cnt", {48'd0, fetch_count}, 64'(9 + 5 * r));
      tick();
      chk("jmp_irpc", {56'd0, ir_pc}, 64'd4);
      chk("jmp_ir", {29'd0, ir}, {29'd0, mk(OP_ACC, 8'h05)});
      for (int k = 0; k < 4; k++) tick();
    end
    chk("loop_cnt", {48'd0, fetch_count}, 64'd23);

    // Wrap 254,255,0,1
    exp_q.push_back(8'd8);
    exp_q.push_back(8'd254);
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    redirect = 1'b1; redirect_target = 8'd254;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_irpc", {56'd0, ir_pc}, 64'((254 + k) % 256));
    end

    // Halt while stalled, then drain
    ir_ready = 1'b0; halt_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("drain_halted", {63'd0, halted}, 64'd0);
      chk("drain_valid", {63'd0, ir_valid}, 64'd1);
      chk("drain_irpc", {56'd0, ir_pc}, 64'd1);
    end
    ir_ready = 1'b1;
    tick();
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_valid", {63'd0, ir_valid}, 64'd0);
    chk("halt_addr", {56'd0, rom_addr}, 64'd2);
    chk("halt_cnt", {48'd0, fetch_count}, 64'd28);
    halt_req = 1'b0; redirect = 1'b1; redirect_target = 8'h40;
    tick();
    redirect = 1'b0;
    chk("halt_redir_addr", {56'd0, rom_addr}, 64'd2);
    chk("halt_redir_halted", {63'd0, halted}, 64'd1);
    tick();
    chk("halt_hold", {63'd0, halted}, 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", {63'd0, halted}, 64'd0);
    chk("resume_addr", {56'd0, rom_addr}, 64'd2);
    chk("resume_valid", {63'd0, ir_valid}, 64'd0);
    push_range(2, 3);
    tick();
    chk("resume_irpc", {56'd0, ir_pc}, 64'd2);
    chk("resume_ir", {29'd0, ir}, {29'd0, rom[2]});
    tick();
    chk("resume_irpc2", {56'd0, ir_pc}, 64'd3);
    chk("resume_cnt", {48'd0, fetch_count}, 64'd29);

    // Async reset mid-stall
    ir_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", {63'd0, ir_valid}, 64'd0);
    chk("arst_addr", {56'd0, rom_addr}, 64'd0);
    chk("arst_cnt", {48'd0, fetch_count}, 64'd0);
    #2;
    rst_n = 1'b1;
    ir_ready = 1'b1;
    push_range(0, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("post_irpc", {56'd0, ir_pc}, 64'(k - 1));
      chk("post_addr", {56'd0, rom_addr}, 64'(k));
    end
    ir_ready = 1'b0;
    tick();
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    chk("post_cnt", {48'd0, fetch_count}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the CPU. Sits between the asynchronous program ROM (8-bit address, 35-bit instruction word) and the decode/execute stage.
- Owns the fetch program counter and drives the ROM address.
- Captures the combinational ROM word into an instruction register (IR) and hands it downstream with a valid/ready handshake.
- Accepts jump redirects from execute, and halt/resume control.

Parameters:
- ADDR_W, 8, program address width (ROM address).
- INSTR_W, 35, instruction word width.
- RESET_PC, 0, fetch address after reset.
- PC_STEP, 1, fetch PC increment per accepted fetch.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_W  address to program ROM; equals fetch_pc register.
- rom_data  in  INSTR_W  combinational ROM output for rom_addr.
- ir  out  INSTR_W  instruction register contents.
- ir_pc  out  ADDR_W  address the current ir was fetched from.
- ir_valid  out  1  ir holds an instruction not yet accepted.
- ir_ready  in  1  downstream accepts ir this cycle when ir_valid=1.
- redirect  in  1  execute requests a jump this cycle.
- redirect_target  in  ADDR_W  jump target (execute supplies instr[7:0] of the JMP).
- halt_req  in  1  stop fetching (level; sampled each cycle).
- resume  in  1  leave halted state (single-cycle pulse).
- halted  out  1  fetch is stopped and IR drained.
- fetch_count  out  CNT_W  count of handshakes (ir_valid & ir_ready).

Behaviour:
- Reset (async assert, sync to clk edge on release):
  - fetch_pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fetch_count=0, state=S_RUN, halted=0.
- Define accept = ir_valid & ir_ready, and load = state==S_RUN & (!ir_valid | accept) & !redirect.
- load edge: ir<=rom_data, ir_pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+PC_STEP.
  - Addition is mod 2^ADDR_W, so 255+1 -> 0.
- accept without load: ir_valid<=0. ir/ir_pc hold their values.
- Stall (ir_valid & !ir_ready): ir, ir_pc and fetch_pc all hold.
- Redirect (any state except S_HALTED):
  - fetch_pc<=redirect_target and ir_valid<=0. The IR is flushed even if accept is also 1 that cycle.
  - fetch_count still increments on that accept.
  - The first IR load from the target happens on the next edge, giving exactly one bubble cycle.
  - Redirect beats load and halt_req in the same cycle. The halt takes effect on the following cycle if still asserted.
- Latency: rom_addr to ir_valid is one edge. Sustained throughput is 1 instruction/cycle with ir_ready=1.
- FSM:
  - S_RUN: halt_req=1 -> S_DRAIN. No new loads from this edge onward.
  - S_DRAIN: waits for !ir_valid, or for accept/redirect that empties the IR, then -> S_HALTED.
    - halt_req deasserted while in S_DRAIN -> S_RUN.
  - S_HALTED: halted=1, fetch_pc frozen, ir_valid=0. redirect is ignored.
    - resume=1 -> S_RUN; fetching restarts from the frozen fetch_pc on the next edge.
    - resume with halt_req still 1: go to S_RUN, then re-enter S_DRAIN on the following cycle.
- fetch_count increments on every accept and wraps at 2^CNT_W.
- A zero ROM word is fetched and issued like any other word. This block does not decode opcodes.
- Reset asserted mid-stall or mid-drain returns immediately to the reset values; pending IR contents are lost.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W and ADDR_W.
  - Instruction field positions, including jump target = [7:0].
  - Opcode/condition codes used by decode/execute.
  - FSM state enum (S_RUN, S_DRAIN, S_HALTED).
- One natural sub-module: program_counter (fetch_pc register with load-target/increment/hold, mod-2^ADDR_W wrap).
- IR, handshake and FSM stay in instr_fetch.

Test Plan:
- Reset, ir_ready=1, ROM[0]=MOV, ROM[1..3]=0 -> rom_addr 0,1,2,3 on successive cycles; ir_pc 0,1,2 one cycle later; ir_valid=1 from first edge; fetch_count=3 after 3 accepts.
- Stall: hold ir_ready=0 for 3 cycles while ir_pc=2 -> ir, ir_pc=2 and rom_addr=3 constant; fetch_count unchanged; release -> ir_pc=3 next edge.
- Redirect loop with ROM[8]=JMP target 4: assert redirect with target 4 when ir_pc=8 -> next cycle ir_valid=0, rom_addr=4; following edge ir_pc=4, ir=ROM[4] (ACC); repeat 3 loops, fetch_count matches accepts.
- Wrap: redirect to 254, ir_ready=1 -> ir_pc sequence 254,255,0,1.
- Halt: halt_req=1 with IR valid and ir_ready=0 for 2 cycles -> state S_DRAIN, halted=0; ready=1 -> halted=1 next edge, rom_addr frozen; redirect ignored; resume pulse -> fetch continues from frozen address.
- Async reset: assert rst_n=0 between edges during a stall -> ir_valid=0, rom_addr=0 immediately, fetch_count=0; release -> normal fetch from 0.
